pc_sequencer: RTL and testbench

Program-counter sequencer for the fetch stage. It drives the existing 32-bit PC register (`ena`/`data_in`, reading back `data_out`) and issues single-cycle instruction-fetch requests. Each PC load is a boot vector, a sequential +4 step, a branch target or an exception vector. Stalls freeze the PC, and redirects raised during a stall are buffered until the stall clears.

---
 rtl/pc_sequencer_if.sv | 13 +
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch request channel between the PC sequencer and the
// instruction memory / cache front end.
//   if_req  : fetch request (driven by the sequencer)
//   if_addr : fetch address (driven by the sequencer, equals current PC)
//   if_ack  : fetch accepted, same-cycle handshake with if_req
interface pc_sequencer_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;

  modport master (output if_req, output if_addr, input  if_ack);
  modport slave  (input  if_req, input  if_addr, output if_ack);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage. Drives the external 32-bit
// PC register (pc_ena/pc_d, reads back pc_q) and issues single-cycle fetch
// requests. PC loads come from the boot vector, a sequential +4 step, a
// branch target or the exception vector. A stall freezes the PC; redirects
// raised while stalled are held in a one-entry pending register and applied
// in the cycle the stall clears.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   pc_q       : current PC (PC register output)
//   pc_d       : next PC (PC register input), bits [1:0] always zero
//   pc_ena     : PC register load enable
//   fetch      : fetch request channel (if_req / if_addr / if_ack)
//   stall      : pipeline stall, freezes PC and suppresses fetch
//   br_valid   : branch/jump redirect request
//   br_target  : branch/jump redirect address
//   exc        : exception redirect request
//   state      : debug view of the FSM (BOOT=0, FETCH=1, HOLD=2)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_q,
  output logic [31:0]           pc_d,
  output logic                  pc_ena,
  pc_sequencer_if.master        fetch,
  input  logic                  stall,
  input  logic                  br_valid,
  input  logic [31:0]           br_target,
  input  logic                  exc,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_pend_v;
  logic        r_pend_exc;
  logic [31:0] r_pend_addr;

  state_t      w_state_nxt;
  logic        w_pend_v_nxt;
  logic        w_pend_exc_nxt;
  logic [31:0] w_pend_addr_nxt;
  logic [31:0] w_pc_raw;
  logic        w_capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= BOOT;
      r_pend_v    <= 1'b0;
      r_pend_exc  <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_exc  <= w_pend_exc_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_v_nxt    = r_pend_v;
    w_pend_exc_nxt  = r_pend_exc;
    w_pend_addr_nxt = r_pend_addr;
    w_pc_raw        = pc_q;
    w_capture       = 1'b0;
    pc_ena          = 1'b0;
    fetch.if_req    = 1'b0;

    case (r_state)
      BOOT: begin
        pc_ena      = 1'b1;
        w_pc_raw    = RESET_PC;
        w_state_nxt = FETCH;
      end
      FETCH: begin
        fetch.if_req = ~stall;
        if (stall) begin
          // The stall cycle itself already records redirects, same as HOLD.
          w_state_nxt = HOLD;
          w_capture   = 1'b1;
        end else if (exc) begin
          pc_ena   = 1'b1;
          w_pc_raw = EXC_VECTOR;
        end else if (br_valid) begin
          pc_ena   = 1'b1;
          w_pc_raw = br_target;
        end else if (fetch.if_ack) begin
          pc_ena   = 1'b1;
          w_pc_raw = pc_q + 32'd4;
        end
      end
      HOLD: begin
        if (stall) begin
          w_capture = 1'b1;
        end else begin
          // Exit cycle: live redirects win over the buffered one, except
          // that a buffered exception still beats a live branch.
          w_state_nxt    = FETCH;
          w_pend_v_nxt   = 1'b0;
          w_pend_exc_nxt = 1'b0;
          if (exc) begin
            pc_ena   = 1'b1;
            w_pc_raw = EXC_VECTOR;
          end else if (br_valid && !r_pend_exc) begin
            pc_ena   = 1'b1;
            w_pc_raw = br_target;
          end else if (r_pend_v) begin
            pc_ena   = 1'b1;
            w_pc_raw = r_pend_addr;
          end
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase

    if (w_capture) begin
      if (exc) begin
        w_pend_addr_nxt = EXC_VECTOR;
        w_pend_v_nxt    = 1'b1;
        w_pend_exc_nxt  = 1'b1;
      end else if (br_valid && !r_pend_exc) begin
        w_pend_addr_nxt = br_target;
        w_pend_v_nxt    = 1'b1;
      end
    end
  end

  assign pc_d          = w_pc_raw & ~32'h0000_0003;
  assign fetch.if_addr = pc_q;
  assign state         = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] EXC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_ena;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc = 1'b0;
  logic [1:0]  state;

  pc_sequencer_if fif ();

  pc_sequencer #(.RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h0000_0080)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_q      (pc_q),
    .pc_d      (pc_d),
    .pc_ena    (pc_ena),
    .fetch     (fif),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc       (exc),
    .state     (state)
  );

  always #5 clk = ~clk;

  // External PC register, with an override used to plant arbitrary PC values.
  logic [31:0] pcreg   = 32'hDEAD_BEEC;
  logic        ovr_en  = 1'b0;
  logic [31:0] ovr_val = '0;
  assign pc_q = ovr_en ? ovr_val : pcreg;
  always @(posedge clk) if (pc_ena) pcreg <= pc_d;

  logic if_ack = 1'b0;
  assign fif.if_ack = if_ack;

  // Reference model: mode 0=boot 1=fetching 2=stalled; redirects seen while
  // stalled are collected in a list and resolved on release.
  typedef struct { bit is_exc; logic [31:0] a; } req_t;
  req_t        pq[$];
  int          m_mode = 0;
  logic [31:0] m_pc = '0;
  logic        e_req, e_ena;
  logic [31:0] e_pd;
  logic [1:0]  e_st;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_expect();
    bit any_exc;
    e_req = 1'b0; e_ena = 1'b0; e_pd = '0; e_st = 2'd0;
    if (!rst || m_mode == 0) begin
      e_ena = 1'b1; e_pd = 32'h0;
    end else if (m_mode == 1) begin
      e_st = 2'd1; e_req = !stall;
      if (!stall) begin
        if (exc)              begin e_ena = 1'b1; e_pd = EXC; end
        else if (br_valid)    begin e_ena = 1'b1; e_pd = {br_target[31:2], 2'b00}; end
        else if (if_ack)      begin e_ena = 1'b1; e_pd = m_pc + 32'd4; end
      end
    end else begin
      e_st = 2'd2;
      if (!stall) begin
        any_exc = exc;
        foreach (pq[i]) if (pq[i].is_exc) any_exc = 1'b1;
        if (any_exc)               begin e_ena = 1'b1; e_pd = EXC; end
        else if (br_valid)         begin e_ena = 1'b1; e_pd = {br_target[31:2], 2'b00}; end
        else if (pq.size() > 0)    begin e_ena = 1'b1; e_pd = pq[pq.size()-1].a; end
      end
    end
  endtask

  task automatic record();
    req_t r;
    if (exc) begin r.is_exc = 1'b1; r.a = EXC; pq.push_back(r); end
    else if (br_valid) begin r.is_exc = 1'b0; r.a = {br_target[31:2], 2'b00}; pq.push_back(r); end
  endtask

  task automatic model_update();
    model_expect();
    if (!rst) begin
      m_mode = 0; pq.delete(); m_pc = 32'h0;
    end else begin
      if (e_ena) m_pc = e_pd;
      case (m_mode)
        0: m_mode = 1;
        1: if (stall) begin m_mode = 2; record(); end
        default: if (stall) record(); else begin m_mode = 1; pq.delete(); end
      endcase
    end
  endtask

  task automatic check_model();
    model_expect();
    chk("if_req", {31'd0, fif.if_req}, {31'd0, e_req});
    chk("pc_ena", {31'd0, pc_ena}, {31'd0, e_ena});
    chk("state", {30'd0, state}, {30'd0, e_st});
    if (e_ena) chk("pc_d", pc_d, e_pd);
    if (rst && m_mode != 0) chk("if_addr", fif.if_addr, m_pc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic s, input logic b, input logic e, input logic a, input logic [31:0] t);
    stall = s; br_valid = b; exc = e; if_ack = a; br_target = t;
  endtask

  // in = {stall, br_valid, exc, if_ack}; rn = {if_req, pc_ena}
  typedef struct {
    logic [3:0]  in;
    logic [31:0] t;
    logic [1:0]  rn;
    logic [31:0] pd;
    logic [1:0]  st;
  } vec_t;
  vec_t tbl[24];

  initial begin
    tbl[0]  = '{4'b0001, 32'h0,   2'b01, 32'h0,   2'd0};
    tbl[1]  = '{4'b0001, 32'h0,   2'b11, 32'h4,   2'd1};
    tbl[2]  = '{4'b0001, 32'h0,   2'b11, 32'h8,   2'd1};
    tbl[3]  = '{4'b0001, 32'h0,   2'b11, 32'hC,   2'd1};
    tbl[4]  = '{4'b0100, 32'h103, 2'b11, 32'h100, 2'd1};
    tbl[5]  = '{4'b0000, 32'h0,   2'b10, 32'h0,   2'd1};
    tbl[6]  = '{4'b1100, 32'h200, 2'b00, 32'h0,   2'd1};
    tbl[7]  = '{4'b1010, 32'h0,   2'b00, 32'h0,   2'd2};
    tbl[8]  = '{4'b1101, 32'h204, 2'b00, 32'h0,   2'd2};
    tbl[9]  = '{4'b0000, 32'h0,   2'b01, 32'h80,  2'd2};
    tbl[10] = '{4'b0001, 32'h0,   2'b11, 32'h84,  2'd1};
    tbl[11] = '{4'b1101, 32'h300, 2'b00, 32'h0,   2'd1};
    tbl[12] = '{4'b1100, 32'h400, 2'b00, 32'h0,   2'd2};
    tbl[13] = '{4'b1000, 32'h0,   2'b00, 32'h0,   2'd2};
    tbl[14] = '{4'b0000, 32'h0,   2'b01, 32'h400, 2'd2};
    tbl[15] = '{4'b0001, 32'h0,   2'b11, 32'h404, 2'd1};
    tbl[16] = '{4'b0111, 32'h1FF, 2'b11, 32'h80,  2'd1};
    tbl[17] = '{4'b1000, 32'h0,   2'b00, 32'h0,   2'd1};
    tbl[18] = '{4'b0100, 32'h52,  2'b01, 32'h50,  2'd2};
    tbl[19] = '{4'b0000, 32'h0,   2'b10, 32'h0,   2'd1};
    tbl[20] = '{4'b0001, 32'h0,   2'b11, 32'h54,  2'd1};
    tbl[21] = '{4'b1001, 32'h0,   2'b00, 32'h0,   2'd1};
    tbl[22] = '{4'b0001, 32'h0,   2'b00, 32'h0,   2'd2};
    tbl[23] = '{4'b0001, 32'h0,   2'b11, 32'h58,  2'd1};

    // Two cycles in reset.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    #1;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("rst_pc_ena", {31'd0, pc_ena}, 32'd1);
      chk("rst_if_req", {31'd0, fif.if_req}, 32'd0);
      chk("rst_state", {30'd0, state}, 32'd0);
      chk("rst_pc_d", pc_d, 32'h0);
      tick();
    end
    rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], tbl[i].t);
      #3;
      chk($sformatf("vec%0d_if_req", i), {31'd0, fif.if_req}, {31'd0, tbl[i].rn[1]});
      chk($sformatf("vec%0d_pc_ena", i), {31'd0, pc_ena}, {31'd0, tbl[i].rn[0]});
      chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
      if (tbl[i].rn[0]) chk($sformatf("vec%0d_pc_d", i), pc_d, tbl[i].pd);
      check_model();
      tick();
    end

    // Sequential step wraps at the top of the address space.
    ovr_en = 1'b1; ovr_val = 32'hFFFF_FFFC; m_pc = 32'hFFFF_FFFC;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    #3;
    chk("wrap_pc_d", pc_d, 32'h0);
    chk("wrap_pc_ena", {31'd0, pc_ena}, 32'd1);
    check_model();
    tick();
    ovr_en = 1'b0;
    #3;
    chk("wrap_if_addr", fif.if_addr, 32'h0);
    check_model();
    tick();

    // Asynchronous reset while holding a pending branch.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h600);
    #3; check_model(); tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #3; check_model();
    #1; rst = 1'b0;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_pc_ena", {31'd0, pc_ena}, 32'd1);
    chk("arst_if_req", {31'd0, fif.if_req}, 32'd0);
    tick();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    #3;
    chk("arst_boot_state", {30'd0, state}, 32'd0);
    chk("arst_boot_pc_d", pc_d, 32'h0);
    check_model();
    tick();
    #3;
    chk("arst_first_addr", fif.if_addr, 32'h0);
    chk("arst_first_req", {31'd0, fif.if_req}, 32'd1);
    chk("arst_next_pc", pc_d, 32'h4);
    check_model();
    tick();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 6, $urandom);
      #3;
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
